fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that shares one NPU `fifo` instance between `NUM_REQ` producers (for example, PE result lanes). It grants one requester at a time for a bounded burst and drives the FIFO write port (`enable`, `wf_en`, `data_in`) from registers. It tracks FIFO occupancy internally, so it never issues a write into a full FIFO. The block sits directly in front of the FIFO; the consumer drives the FIFO read side, and `fifo_rd_en` is mirrored into this block.

## Interface
- `DATA_WIDTH`, 8, width of each requester's data and of the FIFO word
- `DEPTH`, 128, FIFO depth; sets the occupancy counter range 0..DEPTH
- `NUM_REQ`, 4, number of requesters (2..8)
- `BURST_LEN`, 4, maximum beats per grant (1..16)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous reset, active-low
- `req_valid`  in  NUM_REQ  per-requester data valid
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_ready`  out  NUM_REQ  per-requester accept; a beat transfers when valid && ready
- `fifo_rd_en`  in  1  copy of the consumer's FIFO read enable
- `fifo_empty`  in  1  FIFO empty flag; qualifies `fifo_rd_en`
- `fifo_enable`  out  1  FIFO enable, registered
- `fifo_wf_en`  out  1  FIFO write enable, registered
- `fifo_data_in`  out  DATA_WIDTH  FIFO write data, registered
- `grant_id`  out  clog2(NUM_REQ)  index of the current or last granted requester
- `busy`  out  1  high while in state BURST
- `level`  out  clog2(DEPTH+1)  internal occupancy count

## Operation
- States are IDLE and BURST.
- **IDLE:**
  - If any `req_valid` is high, select the first set bit scanning from `rr_ptr` upward, wrapping modulo NUM_REQ.
  - Load `grant_id`, clear `beat_cnt`, and go to BURST.
  - No beat is accepted in IDLE.
- **BURST:**
  - `req_ready[grant_id] = (level < DEPTH)`. All other ready bits are 0.
  - On accept: register the data into `fifo_data_in`, set `fifo_wf_en`=1 for the next cycle, and increment `beat_cnt`.
  - Go to IDLE when an accept occurs with `beat_cnt == BURST_LEN-1`, or when `req_valid[grant_id]` is low.
  - On leaving BURST, set `rr_ptr = (grant_id+1) mod NUM_REQ`.
- **Level accounting:**
  - A write is an accept. A read is `fifo_rd_en && !fifo_empty`.
  - `level` does +1 on a write only, -1 on a read only, and is unchanged when both or neither occur.
  - `level` saturates at 0 and at DEPTH. It counts an accepted beat one cycle before the FIFO stores it, so it is never below the true occupancy.
- **Full:** when `level == DEPTH`, the arbiter stays in BURST with ready low (the grant is held and `beat_cnt` is kept). Writing resumes the cycle after a read lowers `level`.
- `fifo_enable` goes to 1 on the first cycle after reset release and stays 1.

## Timing
- Reset values (applied while `rst`=0, on clk edge): state=IDLE, `rr_ptr`=0, `grant_id`=0, `beat_cnt`=0, `level`=0, `busy`=0, `req_ready`=0, `fifo_enable`=0, `fifo_wf_en`=0, `fifo_data_in`=0.
- Arbitration latency: one cycle from `req_valid` rising in IDLE to `req_ready` high.
- Write latency: one cycle from accept to `fifo_wf_en`/`fifo_data_in` valid.
- Throughput: one beat per cycle within a burst. There is one idle cycle between bursts.
- `req_ready` is combinational from state, `grant_id` and `level`. It has no combinational dependency on `req_valid`.
- Reset asserted mid-burst: outputs clear on that edge. Accepted beats that are not yet written are dropped, and the FIFO must be reset together with this block.

## Configuration
- `FIFO_ARB_PRIO0_EN` defined: in IDLE, requester 0 wins whenever its `req_valid` is high, regardless of `rr_ptr`. Other requesters rotate round-robin, and `rr_ptr` is not updated after a requester-0 grant.
- Not defined: pure round-robin across all requesters.

## Structure
- A shared package `npu_fifo_pkg` holds:
  - the state encoding (`ARB_IDLE`=1'b0, `ARB_BURST`=1'b1);
  - the default `DATA_WIDTH`/`DEPTH` constants, shared with `fifo`.
- One sub-module, `rr_pick`: combinational wrap-around first-set-bit selector taking (`req`, `ptr`) and returning (`idx`, `found`).

## Test plan
- Single requester: after reset, req 1 presents A1,B2,C3 with valid held → grant_id=1, `fifo_wf_en` high for 3 cycles carrying A1,B2,C3, `level`=3, then IDLE.
- Burst cap with BURST_LEN=4: req 0 and req 2 both hold valid → 4 beats from 0, one idle cycle, 4 beats from 2, then back to 0.
- Full: DEPTH=4 with no reads; req 0 sends 6 beats → 4 accepted, `req_ready` low with `level`=4; one `fifo_rd_en` → next beat accepted, `level`=4.
- Simultaneous read and write at `level`=2 → `level` stays 2. Read with `fifo_empty`=1 → `level` unchanged.
- Mid-burst reset: reset during the 2nd beat → on the next edge `fifo_wf_en`=0, `busy`=0, `level`=0, `grant_id`=0.
- With `FIFO_ARB_PRIO0_EN` defined, `rr_ptr`=2 and req 0 and req 3 valid → grant_id=0. Without it → grant_id=3.

Source files
------------

// File: rtl/npu_fifo_pkg.sv
// Shared NPU FIFO definitions: arbiter state encoding and the default FIFO geometry
// (the same DATA_WIDTH/DEPTH defaults the fifo block uses).
package npu_fifo_pkg;

    localparam logic [0:0] ARB_IDLE  = 1'b0;
    localparam logic [0:0] ARB_BURST = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 128;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO-write bundle of fifo_wr_arbiter. The master side holds the producers
// and the FIFO read-side mirror; the slave side is the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = npu_fifo_pkg::DEFAULT_DATA_WIDTH,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_rd_en;
    logic                          fifo_empty;
    logic                          fifo_enable;
    logic                          fifo_wf_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;

    modport master (
        output req_valid, req_data, fifo_rd_en, fifo_empty,
        input  req_ready, fifo_enable, fifo_wf_en, fifo_data_in
    );

    modport slave (
        input  req_valid, req_data, fifo_rd_en, fifo_empty,
        output req_ready, fifo_enable, fifo_wf_en, fifo_data_in
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Wrap-around first-set-bit selector: returns the first set bit of req found scanning
// upward from ptr, modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves it unassigned
        // and no latch is inferred.
        idx   = '0;
        found = 1'b0;
        // Scanning from the far end lets the candidate closest to ptr overwrite the others.
        for (int i = N - 1; i >= 0; i--) begin
            int j;
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (req[W'(j)]) begin
                idx   = W'(j);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst write arbiter in front of one NPU fifo; tracks occupancy so it never
// writes a full FIFO. Define FIFO_ARB_PRIO0_EN to give requester 0 fixed priority in IDLE.
module fifo_wr_arbiter
    import npu_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    fifo_wr_arbiter_if.slave           bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int LVW = $clog2(DEPTH + 1);
    localparam int BCW = $clog2(BURST_LEN) + 1;

    logic [0:0]            state_q, state_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]        grant_id_q, grant_id_d;
    logic [BCW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [LVW-1:0]        level_q, level_d;
    logic                  fifo_enable_q, fifo_enable_d;
    logic                  fifo_wf_en_q, fifo_wf_en_d;
    logic [DATA_WIDTH-1:0] fifo_data_in_q, fifo_data_in_d;

    logic                  not_full, grant_valid, accept, rd_fire;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [IDW-1:0]        rr_idx, pick_idx, next_ptr;
    logic                  rr_found, pick_found;

    assign not_full    = level_q < LVW'(DEPTH);
    assign grant_valid = bus.req_valid[grant_id_q];
    assign grant_data  = bus.req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
    assign accept      = (state_q == ARB_BURST) && not_full && grant_valid;
    assign rd_fire     = bus.fifo_rd_en && !bus.fifo_empty;
    assign next_ptr    = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    rr_pick #(.N(NUM_REQ), .W(IDW)) u_rr_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .idx   (rr_idx),
        .found (rr_found)
    );

`ifdef FIFO_ARB_PRIO0_EN
    assign pick_idx   = bus.req_valid[0] ? '0 : rr_idx;
    assign pick_found = rr_found;
`else
    assign pick_idx   = rr_idx;
    assign pick_found = rr_found;
`endif

    // Ready depends only on registered state, never on req_valid.
    always_comb begin
        bus.req_ready = '0;
        if (state_q == ARB_BURST && not_full) bus.req_ready[grant_id_q] = 1'b1;
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_id_d     = grant_id_q;
        beat_cnt_d     = beat_cnt_q;
        level_d        = level_q;
        fifo_enable_d  = 1'b1;
        fifo_wf_en_d   = accept;
        fifo_data_in_d = accept ? grant_data : fifo_data_in_q;

        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = ARB_BURST;
                end
            end
            default: begin
                if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
                if (!grant_valid || (accept && beat_cnt_q == BCW'(BURST_LEN - 1))) begin
                    state_d = ARB_IDLE;
`ifdef FIFO_ARB_PRIO0_EN
                    if (grant_id_q != '0) rr_ptr_d = next_ptr;
`else
                    rr_ptr_d = next_ptr;
`endif
                end
            end
        endcase

        // A full stall holds the grant; beats counted here reach the FIFO one cycle later.
        case ({accept, rd_fire})
            2'b10:   if (level_q != LVW'(DEPTH)) level_d = level_q + 1'b1;
            2'b01:   if (level_q != '0)          level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples the
        // pre-edge values, independent of statement order.
        if (!rst) begin
            state_q        <= ARB_IDLE;
            rr_ptr_q       <= '0;
            grant_id_q     <= '0;
            beat_cnt_q     <= '0;
            level_q        <= '0;
            fifo_enable_q  <= 1'b0;
            fifo_wf_en_q   <= 1'b0;
            fifo_data_in_q <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_id_q     <= grant_id_d;
            beat_cnt_q     <= beat_cnt_d;
            level_q        <= level_d;
            fifo_enable_q  <= fifo_enable_d;
            fifo_wf_en_q   <= fifo_wf_en_d;
            fifo_data_in_q <= fifo_data_in_d;
        end
    end

    assign bus.fifo_enable  = fifo_enable_q;
    assign bus.fifo_wf_en   = fifo_wf_en_q;
    assign bus.fifo_data_in = fifo_data_in_q;
    assign grant_id         = grant_id_q;
    assign busy             = (state_q == ARB_BURST);
    assign level            = level_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (DEPTH=4 so the full case is reachable); a monitor
// compares every FIFO write against a queue of hand-computed expected words.
module tb_fifo_wr_arbiter;
    localparam int DW = 8;
    localparam int NR = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] grant_id;
    logic       busy;
    logic [2:0] level;

    logic          valid_a [NR];
    logic [DW-1:0] data_a  [NR];
    logic [DW-1:0] exp_q   [$];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .DEPTH(4), .NUM_REQ(NR), .BURST_LEN(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .grant_id (grant_id),
        .busy     (busy),
        .level    (level)
    );

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]          = valid_a[i];
            bus.req_data[i*DW +: DW]  = data_a[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write the DUT presents must match the next expected word.
    always @(negedge clk) begin
        if (bus.fifo_wf_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %0h expected none", bus.fifo_data_in);
            end else begin
                check("fifo_data_in", 32'(bus.fifo_data_in), 32'(exp_q.pop_front()));
            end
        end
    end

    // Presents n beats base, base+step, ... on requester id; called just after a posedge.
    task automatic send(input int id, input int n, input logic [DW-1:0] base,
                        input logic [DW-1:0] step);
        logic [DW-1:0] d;
        logic [1:0]    idx;
        int            t;
        d   = base;
        idx = id[1:0];
        for (int k = 0; k < n; k++) begin
            valid_a[id] = 1'b1;
            data_a[id]  = d;
            t = 0;
            while (1) begin
                @(negedge clk);
                if (bus.req_ready[idx] === 1'b1) break;
                t++;
                if (t > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: req %0d beat %0d got no ready, required ready", id, k);
                    break;
                end
            end
            @(posedge clk);
            #1;
            d = d + step;
        end
        valid_a[id] = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.fifo_rd_en = 1'b1;
        repeat (n) @(posedge clk);
        #1 bus.fifo_rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            valid_a[i] = 1'b0;
            data_a[i]  = '0;
        end
        bus.fifo_rd_en = 1'b0;
        bus.fifo_empty = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wf_en",   32'(bus.fifo_wf_en),   0);
        check("rst_data",    32'(bus.fifo_data_in), 0);
        check("rst_enable",  32'(bus.fifo_enable),  0);
        check("rst_busy",    32'(busy),             0);
        check("rst_level",   32'(level),            0);
        check("rst_grant",   32'(grant_id),         0);
        check("rst_ready",   32'(bus.req_ready),    0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single requester: A1, B2, C3 from requester 1
        exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
        fork
            send(1, 3, 8'hA1, 8'h11);
            begin
                @(posedge clk);
                @(negedge clk);
                check("t1_enable", 32'(bus.fifo_enable), 1);
                check("t1_grant",  32'(grant_id),        1);
                check("t1_busy",   32'(busy),            1);
                check("t1_ready",  32'(bus.req_ready),   32'h2);
            end
        join
        @(posedge clk);
        @(negedge clk);
        check("t1_idle",  32'(busy),  0);
        check("t1_level", 32'(level), 3);
        @(posedge clk);
        #1 drain(4);

        // Arbitration with rr_ptr=2 and requesters 0 and 3 valid
`ifdef FIFO_ARB_PRIO0_EN
        exp_q.push_back(8'h60); exp_q.push_back(8'h63);
`else
        exp_q.push_back(8'h63); exp_q.push_back(8'h60);
`endif
        fork
            send(0, 1, 8'h60, 8'h00);
            send(3, 1, 8'h63, 8'h00);
            begin
                @(posedge clk);
                @(negedge clk);
`ifdef FIFO_ARB_PRIO0_EN
                check("prio_grant", 32'(grant_id), 0);
`else
                check("rr_grant",   32'(grant_id), 3);
`endif
            end
        join
        drain(4);
        do_reset();

        // Burst cap: 4 from req 0, 4 from req 2, then back to req 0 (reads keep level low)
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h10 + 8'(k));
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h20 + 8'(k));
        for (int k = 4; k < 8; k++) exp_q.push_back(8'h10 + 8'(k));
        bus.fifo_rd_en = 1'b1;
        fork
            send(0, 8, 8'h10, 8'h01);
            send(2, 4, 8'h20, 8'h01);
        join
        bus.fifo_rd_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("burst_level", 32'(level), 0);
        check("burst_idle",  32'(busy),  0);
        @(posedge clk);
        #1;

        // Full: req 0 offers 6 beats with no reads
        for (int k = 0; k < 6; k++) exp_q.push_back(8'h30 + 8'(k));
        fork
            send(0, 6, 8'h30, 8'h01);
            begin
                repeat (10) @(posedge clk);
                @(negedge clk);
                check("full_level", 32'(level),         4);
                check("full_ready", 32'(bus.req_ready), 0);
                check("full_busy",  32'(busy),          1);
                @(posedge clk);
                #1 bus.fifo_rd_en = 1'b1;
                @(posedge clk);
                #1 bus.fifo_rd_en = 1'b0;
                @(negedge clk);
                check("read_level",  32'(level),         3);
                check("read_ready",  32'(bus.req_ready), 1);
                @(posedge clk);
                @(negedge clk);
                check("refull_level", 32'(level), 4);
                @(posedge clk);
                #1 bus.fifo_rd_en = 1'b1;
                @(posedge clk);
                #1 bus.fifo_rd_en = 1'b0;
            end
        join

        // Simultaneous read and write at level 2
        drain(2);
        @(negedge clk);
        check("pre_rw_level", 32'(level), 2);
        @(posedge clk);
        #1;
        exp_q.push_back(8'h40);
        fork
            send(1, 1, 8'h40, 8'h00);
            begin
                @(posedge clk);
                #1 bus.fifo_rd_en = 1'b1;
                @(posedge clk);
                #1 bus.fifo_rd_en = 1'b0;
                @(negedge clk);
                check("rw_level", 32'(level), 2);
            end
        join

        // Read while the FIFO reports empty is ignored
        @(posedge clk);
        #1;
        bus.fifo_empty = 1'b1;
        bus.fifo_rd_en = 1'b1;
        @(posedge clk);
        #1;
        bus.fifo_rd_en = 1'b0;
        bus.fifo_empty = 1'b0;
        @(negedge clk);
        check("empty_read_level", 32'(level), 2);

        // Reset asserted while the second beat is on offer
        @(posedge clk);
        #1;
        exp_q.push_back(8'h50);
        valid_a[2] = 1'b1;
        data_a[2]  = 8'h50;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        data_a[2] = 8'h51;
        rst       = 1'b0;
        @(posedge clk);
        #1 valid_a[2] = 1'b0;
        @(negedge clk);
        check("midrst_wf_en",  32'(bus.fifo_wf_en),  0);
        check("midrst_busy",   32'(busy),            0);
        check("midrst_level",  32'(level),           0);
        check("midrst_grant",  32'(grant_id),        0);
        check("midrst_enable", 32'(bus.fifo_enable), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_enable", 32'(bus.fifo_enable), 1);

        repeat (2) @(posedge clk);
        check("scoreboard_left", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
